// File: rtl/reg_file_rename_if.sv
// ROB-side bundle of the register file / rename table: commit writes,
// new-tail renames, mispredict flush and the two dependency queries.
interface reg_file_rename_if #(
  parameter int ROB_WIDTH_BIT = 5,
  parameter int XLEN          = 32
);
  logic                     clear_in;
  logic [4:0]               commit_rd;
  logic [XLEN-1:0]          commit_val;
  logic [ROB_WIDTH_BIT-1:0] commit_rob_id;
  logic [4:0]               rename_rd;
  logic [ROB_WIDTH_BIT-1:0] rename_rob_id;
  logic [ROB_WIDTH_BIT-1:0] rob_q1_id;
  logic [ROB_WIDTH_BIT-1:0] rob_q2_id;
  logic                     rob_q1_ready;
  logic                     rob_q2_ready;
  logic [XLEN-1:0]          rob_q1_val;
  logic [XLEN-1:0]          rob_q2_val;

  // ROB / issue side: drives commits, renames, flush and query answers.
  modport master (
    output clear_in, commit_rd, commit_val, commit_rob_id,
    output rename_rd, rename_rob_id,
    output rob_q1_ready, rob_q2_ready, rob_q1_val, rob_q2_val,
    input  rob_q1_id, rob_q2_id
  );

  // Register file side.
  modport slave (
    input  clear_in, commit_rd, commit_val, commit_rob_id,
    input  rename_rd, rename_rob_id,
    input  rob_q1_ready, rob_q2_ready, rob_q1_val, rob_q2_val,
    output rob_q1_id, rob_q2_id
  );
endinterface

// File: rtl/reg_file_rename.sv
// Architectural register file plus register-status (rename) table.
// Source lookups resolve combinationally against pre-cycle state, with
// bypass from the same-cycle commit and from the ROB's query answers.
module reg_file_rename #(
  parameter int ROB_WIDTH_BIT = 5,
  parameter int XLEN          = 32
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     rdy_in,
  reg_file_rename_if.slave         rob,
  input  logic [4:0]               dec_rs1,
  input  logic [4:0]               dec_rs2,
  output logic                     rs1_dep,
  output logic                     rs2_dep,
  output logic [ROB_WIDTH_BIT-1:0] rs1_tag,
  output logic [ROB_WIDTH_BIT-1:0] rs2_tag,
  output logic [XLEN-1:0]          rs1_val,
  output logic [XLEN-1:0]          rs2_val,
  output logic [31:0]              commit_cnt
);

  typedef logic [ROB_WIDTH_BIT-1:0] rob_id_t;

  typedef struct packed {
    logic            dep;
    rob_id_t         tag;
    logic [XLEN-1:0] val;
  } operand_t;

  logic [XLEN-1:0] regs [32];
  rob_id_t         tag  [32];
  logic [31:0]     busy;

  // Resolve one source operand: architectural value, same-cycle commit
  // bypass, ROB result bypass, or a pending dependency on the ROB tag.
  function automatic operand_t resolve(
    input logic [4:0]      rs,
    input logic            rs_busy,
    input rob_id_t         rs_tag,
    input logic [XLEN-1:0] rs_reg,
    input logic            q_ready,
    input logic [XLEN-1:0] q_val
  );
    operand_t o;
    o = '{dep: 1'b0, tag: '0, val: '0};
    if (!rs_busy) begin
      o.val = rs_reg;
    end else if (rob.commit_rd != 5'd0 && rob.commit_rd == rs &&
                 rob.commit_rob_id == rs_tag) begin
      o.val = rob.commit_val;
    end else if (q_ready) begin
      o.val = q_val;
    end else begin
      o.dep = 1'b1;
      o.tag = rs_tag;
    end
    return o;
  endfunction

  // Combinational operand lookup for both sources; queries go to the ROB
  // using the current mapping so a same-cycle rename is never visible.
  always_comb begin
    operand_t o1;
    operand_t o2;
    o1 = resolve(dec_rs1, busy[dec_rs1], tag[dec_rs1], regs[dec_rs1],
                 rob.rob_q1_ready, rob.rob_q1_val);
    o2 = resolve(dec_rs2, busy[dec_rs2], tag[dec_rs2], regs[dec_rs2],
                 rob.rob_q2_ready, rob.rob_q2_val);
    rob.rob_q1_id = tag[dec_rs1];
    rob.rob_q2_id = tag[dec_rs2];
    rs1_dep       = o1.dep;
    rs1_tag       = o1.tag;
    rs1_val       = o1.val;
    rs2_dep       = o2.dep;
    rs2_tag       = o2.tag;
    rs2_val       = o2.val;
  end

  // Commit writes, rename allocation and flush; frozen while rdy_in is low.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      // NOTE: the register array is reset explicitly because reads of x1..x31
      // before any commit must return zero; this costs a reset on every flop.
      regs       <= '{default: '0};
      tag        <= '{default: '0};
      busy       <= '0;
      commit_cnt <= '0;
    end else if (rdy_in) begin
      // NOTE: later non-blocking assignments to the same bit win, so the
      // order below encodes priority: commit-clear < rename < flush.
      if (rob.commit_rd != 5'd0) begin
        regs[rob.commit_rd] <= rob.commit_val;
        commit_cnt          <= commit_cnt + 32'd1;
        if (tag[rob.commit_rd] == rob.commit_rob_id) begin
          busy[rob.commit_rd] <= 1'b0;
        end
      end
      if (rob.rename_rd != 5'd0 && !rob.clear_in) begin
        busy[rob.rename_rd] <= 1'b1;
        tag[rob.rename_rd]  <= rob.rename_rob_id;
      end
      if (rob.clear_in) begin
        busy <= '0;
      end
    end
  end

endmodule

// File: doc/reg_file_rename.md
Name: reg_file_rename

Overview:
- Architectural register file plus register-status (rename) table for the out-of-order RISC-V core.
- Sits between decoder and reorder buffer. Takes rename requests at issue and commit writes at retire.
- Forwards each decoder source-operand lookup to the ROB and returns either a ready value or a ROB dependency tag.
- It is the consumer end of the ROB's commit/new-tail/dependency-query interface.

Parameters:
- ROB_WIDTH_BIT, 5, width of a ROB entry index (ROB has 2^ROB_WIDTH_BIT entries).
- XLEN, 32, register data width.

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous active-low reset
- rdy_in  input  1  global ready; low freezes all state
- clear_in  input  1  mispredict flush from ROB
- commit_rd  input  5  register written at commit; 0 = no commit
- commit_val  input  XLEN  commit data
- commit_rob_id  input  ROB_WIDTH_BIT  ROB entry being committed
- rename_rd  input  5  destination of newly issued instruction; 0 = none
- rename_rob_id  input  ROB_WIDTH_BIT  ROB tail entry allocated to rename_rd
- dec_rs1, dec_rs2  input  5 each  decoder source register indices
- rs1_dep, rs2_dep  output  1 each  1 = operand pending, tag valid
- rs1_tag, rs2_tag  output  ROB_WIDTH_BIT each  ROB entry producing the operand
- rs1_val, rs2_val  output  XLEN each  operand value when dep = 0
- rob_q1_id, rob_q2_id  output  ROB_WIDTH_BIT each  ROB entry queried for rs1/rs2
- rob_q1_ready, rob_q2_ready  input  1 each  ROB says queried entry has a result
- rob_q1_val, rob_q2_val  input  XLEN each  ROB result for queried entry
- commit_cnt  output  32  number of architectural register writes retired

Behaviour:
- State: regs[0..31] (XLEN), busy[0..31], tag[0..31] (ROB_WIDTH_BIT), commit_cnt.
- Reset (rst_n_in low, async): regs = 0, busy = 0, tag = 0, commit_cnt = 0.
  - Combinational outputs then resolve to dep = 0, val = 0, tag = 0, rob_q ids = 0.
- x0: never written or renamed, always reads value 0 with dep = 0. Requests with rd = 0 are no-ops.
- Lookup (combinational, per source s in {rs1, rs2}; shown for rs1):
  - rob_q1_id = tag[dec_rs1].
  - If busy[dec_rs1] = 0 → dep = 0, val = regs[dec_rs1], tag = 0.
  - Else if commit this cycle has commit_rd = dec_rs1 and commit_rob_id = tag[dec_rs1] → dep = 0, val = commit_val.
  - Else if rob_q1_ready → dep = 0, val = rob_q1_val.
  - Else → dep = 1, tag = tag[dec_rs1], val = 0.
  - Lookups use pre-cycle state and never see the same-cycle rename, so that "addi x1,x1,1" reads x1's old mapping.
- Sequential update on posedge, only when rdy_in = 1; otherwise hold everything.
  - Commit (commit_rd ≠ 0):
    - regs[commit_rd] <= commit_val and commit_cnt += 1.
    - busy[commit_rd] clears only if tag[commit_rd] = commit_rob_id and no same-cycle rename of that register.
  - Rename (rename_rd ≠ 0): busy <= 1, tag <= rename_rob_id.
    - Rename wins over a commit-clear on the same register.
- Flush (clear_in = 1 with rdy_in = 1):
  - All busy cleared; tags are don't-care.
  - Same-cycle rename is discarded.
  - Same-cycle commit still writes regs and counts.
  - regs otherwise unchanged.
- Reset asserted mid-operation aborts any update immediately.
- Latency: operand lookup is 0 cycles. Rename/commit effects are visible to lookups from the next cycle.
- Tag wraparound: tag compare is exact equality over ROB_WIDTH_BIT bits, so no special handling is needed.

Test Plan:
- Reset, then look up x5 → dep = 0, val = 0. Commit x0 = 0xDEAD → x0 still reads 0 and commit_cnt = 0.
- Rename x3→tag 7, next cycle look up x3 with rob_q1_ready = 0 → rs1_dep = 1, rs1_tag = 7, rob_q1_id = 7. Set rob_q1_ready = 1, val 0x55 → dep = 0, val = 0x55.
- x3 busy tag 7: commit x3 = 0x11 id 7 while looking up rs2 = x3 → same cycle rs2_val = 0x11, dep = 0. Next cycle busy = 0, regs[3] = 0x11, commit_cnt = 1.
- Stale commit: rename x4→tag 2, rename x4→tag 9, commit x4 = 0x22 id 2 → regs[4] = 0x22, x4 still dep with tag 9.
- Commit x6 id 1 and rename x6 → tag 12 same cycle, lookup rs1 = x6 → old mapping returned. Next cycle x6 dep tag 12, regs[6] = commit value.
- Rename x8, x9, then clear_in with commit x8 = 0x77 and rename x10 → next cycle x8 = 0x77, x9/x10 not busy. Separately, drive rdy_in = 0 with commit → no state change.
